// File: rtl/ultrasonic_pkg.sv
// rtl/ultrasonic_pkg.sv - shared state encoding, 100 MHz timing defaults and width helper
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    // 100 MHz defaults: 10 us trigger, 58.3 us of round trip per cm,
    // 30 ms echo timeout, 50 ms settle between channels.
    localparam int TRIG_CYC    = 1000;
    localparam int CM_CYC      = 5830;
    localparam int ECHO_TO_CYC = 3_000_000;
    localparam int GAP_CYC     = 5_000_000;

    // Channel index width; a single sensor still gets a 1-bit index.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - multi-bit 2-FF synchroniser for the raw echo pins
module echo_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two capture stages; every echo edge reaches the FSM two cycles late.
    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// rtl/ultrasonic_ranger_mc.sv - round-robin multi-channel ultrasonic ranging controller
module ultrasonic_ranger_mc #(
    parameter int NUM_CH      = 3,
    parameter int DIST_W      = 10,
    parameter int TRIG_CYC    = ultrasonic_pkg::TRIG_CYC,
    parameter int CM_CYC      = ultrasonic_pkg::CM_CYC,
    parameter int MAX_DIST    = 400,
    parameter int ECHO_TO_CYC = ultrasonic_pkg::ECHO_TO_CYC,
    parameter int GAP_CYC     = ultrasonic_pkg::GAP_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       start,
    input  logic [NUM_CH-1:0]          echo,
    output logic [NUM_CH-1:0]          trig,
    output logic [NUM_CH*DIST_W-1:0]   distance,
    output logic [NUM_CH-1:0]          valid,
    output logic [NUM_CH-1:0]          err,
    output logic                       done,
    output logic [2:0]                 done_ch,
    output logic                       busy
);

    import ultrasonic_pkg::*;

    localparam int CH_W   = ch_w(NUM_CH);
    localparam int TICK_W = $clog2(CM_CYC + 1);

    logic [NUM_CH-1:0]        echo_s;

    state_e                   state_q, state_d;
    logic [31:0]              timer_q, timer_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     sweep_q, sweep_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [DIST_W-1:0]        dist_q, dist_d;
    logic [NUM_CH*DIST_W-1:0] bank_q, bank_d;
    logic [NUM_CH-1:0]        valid_q, valid_d;
    logic [NUM_CH-1:0]        err_q, err_d;
    logic                     done_q, done_d;
    logic [2:0]               done_ch_q, done_ch_d;

    logic                     echo_cur;
    logic                     tick_wrap;
    logic [DIST_W-1:0]        dist_sat;
    logic [DIST_W-1:0]        dist_next;

    echo_sync #(
        .WIDTH (NUM_CH)
    ) u_echo_sync (
        .clk      (clk),
        .resetn_i (reset),
        .async_i  (echo),
        .sync_o   (echo_s)
    );

    // Only the channel being ranged is looked at; other echoes are ignored.
    assign echo_cur  = echo_s[ch_q];

    // Divider-free centimetre count: a CM_CYC-cycle tick prescaler feeds a
    // saturating centimetre counter. dist_next already includes this cycle,
    // so the cycle that sees echo fall is counted as part of the pulse.
    assign tick_wrap = (tick_q == TICK_W'(CM_CYC - 1));
    assign dist_sat  = (dist_q >= DIST_W'(MAX_DIST)) ? dist_q : dist_q + 1'b1;
    assign dist_next = tick_wrap ? dist_sat : dist_q;

    // Next-state, shared timer, counters and per-channel result banks.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 32'd1;
        ch_d      = ch_q;
        sweep_d   = sweep_q;
        tick_d    = tick_q;
        dist_d    = dist_q;
        bank_d    = bank_q;
        valid_d   = valid_q;
        err_d     = err_q;
        done_d    = 1'b0;
        done_ch_d = done_ch_q;

        unique case (state_q)
            ST_IDLE: begin
                // A start while a single-shot sweep is pending is absorbed.
                if (enable || sweep_q || start) begin
                    state_d = ST_TRIG;
                    if (start && !enable && !sweep_q) begin
                        sweep_d = 1'b1;
                    end
                end
            end

            ST_TRIG: begin
                if (timer_q == 32'(TRIG_CYC - 1)) begin
                    state_d = ST_WAIT_ECHO;
                end
            end

            ST_WAIT_ECHO: begin
                if (echo_cur) begin
                    tick_d  = '0;
                    dist_d  = '0;
                    state_d = ST_MEASURE;
                end else if (timer_q == 32'(ECHO_TO_CYC - 1)) begin
                    err_d[ch_q] = 1'b1;
                    done_d      = 1'b1;
                    done_ch_d   = 3'(ch_q);
                    state_d     = ST_GAP;
                end
            end

            ST_MEASURE: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                dist_d = dist_next;
                // Echo falling wins over an overrun on the same cycle.
                if (!echo_cur) begin
                    bank_d[int'(ch_q)*DIST_W +: DIST_W] = dist_next;
                    valid_d[ch_q] = 1'b1;
                    err_d[ch_q]   = 1'b0;
                    done_d        = 1'b1;
                    done_ch_d     = 3'(ch_q);
                    state_d       = ST_GAP;
                end else if (timer_q == 32'(ECHO_TO_CYC - 1)) begin
                    err_d[ch_q] = 1'b1;
                    done_d      = 1'b1;
                    done_ch_d   = 3'(ch_q);
                    state_d     = ST_GAP;
                end
            end

            ST_GAP: begin
                if (timer_q == 32'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        ch_d    = '0;
                        sweep_d = 1'b0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One timer serves every state, restarting from zero on entry.
        if (state_d != state_q || state_q == ST_IDLE) begin
            timer_d = '0;
        end
    end

    // State, counters and result registers; reset returns to channel 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ch_q      <= '0;
            sweep_q   <= 1'b0;
            tick_q    <= '0;
            dist_q    <= '0;
            bank_q    <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ch_q      <= ch_d;
            sweep_q   <= sweep_d;
            tick_q    <= tick_d;
            dist_q    <= dist_d;
            bank_q    <= bank_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
        end
    end

    // Trigger decoded from registered state so it drops on the reset edge.
    always_comb begin
        trig = '0;
        if (state_q == ST_TRIG) begin
            trig[ch_q] = 1'b1;
        end
    end

    assign distance = bank_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign done     = done_q;
    assign done_ch  = done_ch_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// tb/tb_ultrasonic_ranger_mc.sv - directed bench with behavioural result model
module tb_ultrasonic_ranger_mc;

    localparam int NCH  = 3;
    localparam int DW   = 10;
    localparam int TRIG = 4;
    localparam int CM   = 10;
    localparam int ETO  = 80;
    localparam int GAP  = 8;

    localparam int K_GOOD    = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_STUCK   = 2;

    logic            clk    = 1'b0;
    logic            reset  = 1'b0;
    logic            enable = 1'b0;
    logic            start  = 1'b0;
    logic [NCH-1:0]  echo   = '0;

    logic [NCH-1:0]    trig_a, valid_a, err_a, trig_b, valid_b, err_b;
    logic [NCH*DW-1:0] distance_a, distance_b;
    logic              done_a, busy_a, done_b, busy_b;
    logic [2:0]        done_ch_a, done_ch_b;

    ultrasonic_ranger_mc #(
        .NUM_CH(NCH), .DIST_W(DW), .TRIG_CYC(TRIG), .CM_CYC(CM),
        .MAX_DIST(20), .ECHO_TO_CYC(ETO), .GAP_CYC(GAP)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .echo(echo),
        .trig(trig_a), .distance(distance_a), .valid(valid_a), .err(err_a),
        .done(done_a), .done_ch(done_ch_a), .busy(busy_a)
    );

    ultrasonic_ranger_mc #(
        .NUM_CH(NCH), .DIST_W(DW), .TRIG_CYC(TRIG), .CM_CYC(CM),
        .MAX_DIST(3), .ECHO_TO_CYC(ETO), .GAP_CYC(GAP)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .echo(echo),
        .trig(trig_b), .distance(distance_b), .valid(valid_b), .err(err_b),
        .done(done_b), .done_ch(done_ch_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int ch;
        int kind;
        int n;
        int at;
    } exp_t;

    exp_t q[$];
    int   m_dist  [2][NCH];
    bit   m_valid [2][NCH];
    bit   m_err   [2][NCH];
    int   maxd    [2] = '{20, 3};

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    function automatic logic [NCH*DW-1:0] pk_dist(input int i);
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = DW'(m_dist[i][k]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] pk_bits(input int i, input bit sel_err);
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k] = sel_err ? m_err[i][k] : m_valid[i][k];
        return r;
    endfunction

    function automatic int dget(input logic [NCH*DW-1:0] v, input int ch);
        return int'(v[ch*DW +: DW]);
    endfunction

    // Result model: floor(echo cycles / CM), saturated, applied at the predicted done cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc == q[0].at) begin
            chk(done_a && done_b, "done_pulse", int'({done_a, done_b}), 3);
            chk(int'(done_ch_a) == q[0].ch, "done_ch_a", int'(done_ch_a), q[0].ch);
            chk(int'(done_ch_b) == q[0].ch, "done_ch_b", int'(done_ch_b), q[0].ch);
            for (int i = 0; i < 2; i++) begin
                if (q[0].kind == K_GOOD) begin
                    m_dist[i][q[0].ch]  = (q[0].n / CM > maxd[i]) ? maxd[i] : q[0].n / CM;
                    m_valid[i][q[0].ch] = 1'b1;
                    m_err[i][q[0].ch]   = 1'b0;
                end else begin
                    m_err[i][q[0].ch] = 1'b1;
                end
            end
            void'(q.pop_front());
        end else begin
            chk(!done_a && !done_b, "stray_done", int'({done_a, done_b}), 0);
        end
        chk(distance_a == pk_dist(0), "distance_a", int'(distance_a), int'(pk_dist(0)));
        chk(distance_b == pk_dist(1), "distance_b", int'(distance_b), int'(pk_dist(1)));
        chk(valid_a == pk_bits(0, 1'b0), "valid_a", int'(valid_a), int'(pk_bits(0, 1'b0)));
        chk(valid_b == pk_bits(1, 1'b0), "valid_b", int'(valid_b), int'(pk_bits(1, 1'b0)));
        chk(err_a == pk_bits(0, 1'b1), "err_a", int'(err_a), int'(pk_bits(0, 1'b1)));
        chk(err_b == pk_bits(1, 1'b1), "err_b", int'(err_b), int'(pk_bits(1, 1'b1)));
        chk($countones(trig_a) <= 1, "trig_onehot", int'(trig_a), 0);
    end

    task automatic wait_trig(input int ch, output int e);
        int n = 0;
        while (trig_a[ch] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(n < 300, "trig_seen", n, 0);
        e = cyc;
    endtask

    task automatic run_ch(input int ch, input int kind, input int n, input int exp_rise,
                          input bit xtalk, input bit drop_en, input bit poke, output int d_at);
        int   e, k, f;
        exp_t x;
        wait_trig(ch, e);
        chk(e == exp_rise, "trig_rise_cycle", e, exp_rise);
        chk(trig_a == 3'(1 << ch), "trig_channel", int'(trig_a), 1 << ch);
        k = 0;
        while (trig_a[ch] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(k == TRIG, "trig_width", k, TRIG);
        chk(busy_a && busy_b, "busy_mid", int'({busy_a, busy_b}), 3);
        x.ch = ch;
        x.kind = kind;
        x.n = n;
        if (kind == K_TIMEOUT) begin
            x.at = cyc + ETO;
            q.push_back(x);
        end else begin
            echo[ch] = 1'b1;
            if (xtalk) echo[2] = 1'b1;
            f = cyc + 1;
            x.at = (kind == K_GOOD) ? f + n + 2 : f + 2 + ETO;
            q.push_back(x);
            if (kind == K_GOOD) begin
                for (int i = 1; i <= n; i++) begin
                    @(negedge clk);
                    if (xtalk && i == 10) echo[2] = 1'b0;
                    if (drop_en && i == n / 2) enable = 1'b0;
                    if (poke) start = (i == 20);
                end
                echo[ch] = 1'b0;
            end
        end
        d_at = x.at;
        k = 0;
        while (q.size() > 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(q.size() == 0, "result_arrived", q.size(), 0);
        q.delete();
        echo = '0;
    endtask

    task automatic check_idle_after(input int d);
        int bad = 0;
        while (cyc < d + GAP - 1) @(negedge clk);
        chk(busy_a && busy_b, "busy_last_gap", int'({busy_a, busy_b}), 3);
        @(negedge clk);
        chk(!busy_a && !busy_b, "busy_fall", int'({busy_a, busy_b}), 0);
        repeat (30) begin
            @(negedge clk);
            if (busy_a || trig_a != '0) bad++;
        end
        chk(bad == 0, "stays_idle", bad, 0);
    endtask

    initial begin
        int s, d, e;
        repeat (3) @(negedge clk);
        chk(trig_a == '0, "rst_trig", int'(trig_a), 0);
        chk(distance_a == '0, "rst_distance", int'(distance_a), 0);
        chk(valid_a == '0 && err_a == '0, "rst_valid_err", int'({valid_a, err_a}), 0);
        chk(!done_a && done_ch_a == 3'd0, "rst_done", int'({done_a, done_ch_a}), 0);
        chk(!busy_a, "rst_busy", int'(busy_a), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single-shot sweep of good echoes
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        run_ch(0, K_GOOD, 73, s + 1, 0, 0, 0, d);
        chk(dget(distance_a, 0) == 7, "lit_d0_73", dget(distance_a, 0), 7);
        chk(dget(distance_b, 0) == 3, "lit_d0_sat", dget(distance_b, 0), 3);
        run_ch(1, K_GOOD, 25, d + GAP + 1, 0, 0, 0, d);
        run_ch(2, K_GOOD, 10, d + GAP + 1, 0, 0, 0, d);
        chk(dget(distance_a, 2) == 1, "lit_d2_10", dget(distance_a, 2), 1);
        check_idle_after(d);

        // Overrun, timeout, saturation
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        run_ch(0, K_STUCK, 0, s + 1, 0, 0, 0, d);
        run_ch(1, K_TIMEOUT, 0, d + GAP + 1, 0, 0, 0, d);
        run_ch(2, K_GOOD, 45, d + GAP + 1, 0, 0, 0, d);
        check_idle_after(d);
        chk(dget(distance_a, 0) == 7 && err_a[0], "lit_overrun_keep", dget(distance_a, 0), 7);
        chk(dget(distance_a, 1) == 2 && err_a[1] && valid_a[1], "lit_timeout_keep",
            dget(distance_a, 1), 2);
        chk(dget(distance_a, 2) == 4 && !err_a[2], "lit_d2_45", dget(distance_a, 2), 4);
        chk(dget(distance_b, 2) == 3 && !err_b[2], "lit_d2_45_sat", dget(distance_b, 2), 3);

        // Continuous mode, enable dropped during ch1 measurement
        enable = 1'b1;
        s = cyc;
        run_ch(0, K_GOOD, 80, s + 1, 0, 0, 0, d);
        chk(dget(distance_a, 0) == 8 && !err_a[0], "lit_d0_80", dget(distance_a, 0), 8);
        run_ch(1, K_GOOD, 9, d + GAP + 1, 0, 0, 0, d);
        run_ch(2, K_GOOD, 5, d + GAP + 1, 0, 0, 0, d);
        run_ch(0, K_GOOD, 30, d + GAP + 1, 0, 0, 0, d);
        run_ch(1, K_GOOD, 40, d + GAP + 1, 0, 1, 0, d);
        check_idle_after(d);
        chk(dget(distance_a, 1) == 4 && dget(distance_b, 1) == 3, "lit_d1_40",
            dget(distance_a, 1), 4);

        // Reset while ch2 trigger is high
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_trig(2, e);
        chk(e == s + 1, "trig2_rise", e, s + 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NCH; k++) begin
                m_dist[i][k] = 0;
                m_valid[i][k] = 1'b0;
                m_err[i][k] = 1'b0;
            end
        end
        @(negedge clk);
        chk(trig_a == '0, "rst_mid_trig", int'(trig_a), 0);
        chk(distance_a == '0 && valid_a == '0, "rst_mid_clear", int'(distance_a), 0);
        chk(!busy_a, "rst_mid_busy", int'(busy_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Cross-talk on echo[2] and a start pulse while busy
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        run_ch(0, K_GOOD, 37, s + 1, 1, 0, 1, d);
        chk(dget(distance_a, 2) == 0 && !valid_a[2], "lit_xtalk", dget(distance_a, 2), 0);
        chk(dget(distance_a, 0) == 3, "lit_d0_37", dget(distance_a, 0), 3);
        run_ch(1, K_GOOD, 15, d + GAP + 1, 0, 0, 0, d);
        run_ch(2, K_GOOD, 50, d + GAP + 1, 0, 0, 0, d);
        check_idle_after(d);
        chk(dget(distance_a, 2) == 5 && dget(distance_b, 2) == 3, "lit_d2_50",
            dget(distance_a, 2), 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
